// File: rtl/apb_req_arbiter_if.sv
// Requester-side and APB-master-side signals of the request arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface apb_req_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    // Requester side
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    req_wr;
    logic [NUM_REQ*8-1:0]  req_addr;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [NUM_REQ*4-1:0]  req_strb;
    logic [NUM_REQ-1:0]    req_done;
    logic [NUM_REQ-1:0]    req_err;
    logic [31:0]           req_rdata;
    logic [NUM_REQ-1:0]    grant;
    logic                  busy;
    logic                  timeout;

    // APB master command port
    logic                  transfer;
    logic                  write_read;
    logic [7:0]            addr_in;
    logic [31:0]           wdata_in;
    logic [3:0]            strb_in;
    logic                  transfer_done;
    logic                  error;
    logic [31:0]           rdata_out;

    modport slave (
        input  req, req_wr, req_addr, req_wdata, req_strb,
        input  transfer_done, error, rdata_out,
        output req_done, req_err, req_rdata, grant, busy, timeout,
        output transfer, write_read, addr_in, wdata_in, strb_in
    );

    modport master (
        output req, req_wr, req_addr, req_wdata, req_strb,
        output transfer_done, error, rdata_out,
        input  req_done, req_err, req_rdata, grant, busy, timeout,
        input  transfer, write_read, addr_in, wdata_in, strb_in
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master command port among NUM_REQ requesters,
// with a per-transfer watchdog and a one-cycle completion pulse back to the winner.
module apb_req_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input logic              PCLK,
    input logic              PRESET,
    apb_req_arbiter_if.slave bus
);
    localparam int unsigned IdxW  = $clog2(NUM_REQ);
    localparam int unsigned WdogW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e             state_q;
    logic [IdxW-1:0]    last_ptr_q;
    logic [IdxW-1:0]    gidx_q;
    logic [WdogW-1:0]   wdog_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] req_done_q;
    logic [NUM_REQ-1:0] req_err_q;
    logic [31:0]        req_rdata_q;
    logic               busy_q;
    logic               timeout_q;
    logic               transfer_q;
    logic               write_read_q;
    logic [7:0]         addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         strb_q;

    logic               pick_vld;
    logic [IdxW-1:0]    pick_idx;
    logic [IdxW-1:0]    scan_idx;

    // First requesting index after the last winner, wrapping modulo NUM_REQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_idx = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            scan_idx = IdxW'((32'(last_ptr_q) + k) % NUM_REQ);
            if (!pick_vld && bus.req[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q      <= StIdle;
            last_ptr_q   <= IdxW'(NUM_REQ - 1);
            gidx_q       <= '0;
            wdog_q       <= '0;
            grant_q      <= '0;
            req_done_q   <= '0;
            req_err_q    <= '0;
            req_rdata_q  <= '0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            transfer_q   <= 1'b0;
            write_read_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            strb_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_vld) begin
                        write_read_q <= bus.req_wr[pick_idx];
                        addr_q       <= bus.req_addr[pick_idx*8 +: 8];
                        wdata_q      <= bus.req_wdata[pick_idx*32 +: 32];
                        strb_q       <= bus.req_strb[pick_idx*4 +: 4];
                        gidx_q       <= pick_idx;
                        grant_q      <= NUM_REQ'(1) << pick_idx;
                        transfer_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        wdog_q       <= '0;
                        state_q      <= StBusy;
                    end
                end
                StBusy: begin
                    wdog_q <= wdog_q + 1'b1;
                    // transfer_done takes precedence over a coinciding watchdog expiry
                    if (bus.transfer_done) begin
                        transfer_q  <= 1'b0;
                        req_done_q  <= grant_q;
                        req_err_q   <= grant_q & {NUM_REQ{bus.error}};
                        req_rdata_q <= bus.rdata_out;
                        last_ptr_q  <= gidx_q;
                        state_q     <= StDone;
                    end else if (wdog_q == WdogW'(TIMEOUT_CYC - 1)) begin
                        transfer_q  <= 1'b0;
                        req_done_q  <= grant_q;
                        req_err_q   <= grant_q;
                        req_rdata_q <= '0;
                        timeout_q   <= 1'b1;
                        last_ptr_q  <= gidx_q;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    req_done_q <= '0;
                    req_err_q  <= '0;
                    timeout_q  <= 1'b0;
                    wdog_q     <= '0;
                    grant_q    <= '0;
                    busy_q     <= 1'b0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_done   = req_done_q;
    assign bus.req_err    = req_err_q;
    assign bus.req_rdata  = req_rdata_q;
    assign bus.grant      = grant_q;
    assign bus.busy       = busy_q;
    assign bus.timeout    = timeout_q;
    assign bus.transfer   = transfer_q;
    assign bus.write_read = write_read_q;
    assign bus.addr_in    = addr_q;
    assign bus.wdata_in   = wdata_q;
    assign bus.strb_in    = strb_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Randomized transaction-level bench for apb_req_arbiter against a round-robin
// reference model that tracks only the last winner.
module tb_apb_req_arbiter;
    localparam int NR = 4;
    localparam int TO = 16;

    logic PCLK = 1'b0;
    logic PRESET;
    always #5 PCLK = ~PCLK;

    apb_req_arbiter_if #(.NUM_REQ(NR)) bus ();

    apb_req_arbiter #(
        .NUM_REQ    (NR),
        .TIMEOUT_CYC(TO)
    ) dut (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int last_w   = NR - 1;
    logic [7:0] last_addr = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Round-robin model: first set request after the previous winner.
    function automatic int rr_pick(input logic [NR-1:0] r);
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (last_w + k) % NR;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic shuffle_fields();
        bus.req_wr    = 4'($urandom());
        bus.req_addr  = $urandom();
        bus.req_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.req_strb  = 16'($urandom());
    endtask

    // Entered at a negedge with the DUT idle. done_at: BUSY cycle on which the master
    // completes (1..TO); anything else means the master never answers.
    task automatic run_txn(input logic [NR-1:0] reqv, input int done_at, input bit drop);
        int w;
        bit to;
        logic [0:0]  e_wr;
        logic [7:0]  e_addr;
        logic [31:0] e_wdata, rd;
        logic [3:0]  e_strb;
        logic        err;
        logic [NR-1:0] onehot;
        shuffle_fields();
        bus.req = reqv;
        w       = rr_pick(reqv);
        onehot  = NR'(1) << w;
        e_wr    = bus.req_wr[w];
        e_addr  = bus.req_addr[w*8 +: 8];
        e_wdata = bus.req_wdata[w*32 +: 32];
        e_strb  = bus.req_strb[w*4 +: 4];
        err     = 1'b0;
        rd      = '0;
        @(posedge PCLK); #1;
        check_val("grant", 32'(bus.grant), 32'(onehot));
        check_val("xfer_start", {bus.transfer, bus.busy}, 2'b11);
        check_val("cmd", {bus.write_read, bus.addr_in, bus.strb_in}, {e_wr, e_addr, e_strb});
        check_val("wdata", bus.wdata_in, e_wdata);
        for (int c = 1; c <= TO; c++) begin
            @(negedge PCLK);
            shuffle_fields();
            if (drop) bus.req[w] = 1'b0;
            else bus.req = 4'($urandom());
            bus.transfer_done = (c == done_at);
            bus.error         = 1'($urandom());
            bus.rdata_out     = $urandom();
            err = bus.error;
            rd  = bus.rdata_out;
            @(posedge PCLK); #1;
            if (c == done_at || c == TO) break;
            check_val("busy_hold", {bus.transfer, bus.addr_in, 4'(bus.req_done)}, {1'b1, e_addr, 4'h0});
        end
        to = (done_at < 1 || done_at > TO);
        check_val("done", 32'(bus.req_done), 32'(onehot));
        check_val("err", 32'(bus.req_err), (to || err) ? 32'(onehot) : 32'h0);
        check_val("rdata", bus.req_rdata, to ? 32'h0 : rd);
        check_val("end_flags", {bus.timeout, bus.transfer, bus.busy}, {to, 1'b0, 1'b1});
        last_w    = w;
        last_addr = e_addr;
        @(negedge PCLK);
        bus.transfer_done = 1'($urandom());
        bus.error         = 1'b1;
        @(posedge PCLK); #1;
        check_val("after_done", {4'(bus.req_done), 4'(bus.grant), bus.timeout, bus.busy, bus.transfer},
                  11'h0);
        @(negedge PCLK);
        bus.transfer_done = 1'b0;
        bus.req           = '0;
    endtask

    task automatic idle_cycles(input int n);
        bus.req = '0;
        for (int i = 0; i < n; i++) begin
            bus.transfer_done = 1'($urandom());
            @(posedge PCLK); #1;
            check_val("idle", {bus.transfer, bus.busy, bus.addr_in}, {2'b00, last_addr});
            @(negedge PCLK);
        end
        bus.transfer_done = 1'b0;
    endtask

    initial begin
        PRESET            = 1'b1;
        bus.req           = '0;
        bus.transfer_done = 1'b0;
        bus.error         = 1'b0;
        bus.rdata_out     = '0;
        shuffle_fields();
        repeat (2) @(posedge PCLK);
        #1;
        check_val("rst_out", {4'(bus.req_done), 4'(bus.req_err), 4'(bus.grant), bus.busy,
                  bus.timeout, bus.transfer, bus.write_read, bus.addr_in, bus.strb_in}, 24'h0);
        check_val("rst_data", bus.req_rdata | bus.wdata_in, 32'h0);
        @(negedge PCLK);
        PRESET = 1'b0;

        run_txn(4'b0001, 2, 1'b0);
        repeat (5) run_txn(4'b1111, 1, 1'b0);
        run_txn(4'b0100, 3, 1'b0);
        run_txn(4'b0010, 0, 1'b0);
        run_txn(4'b1010, TO, 1'b0);
        run_txn(4'b0010, 4, 1'b1);
        idle_cycles(3);

        // Reset in the middle of requester 3's transfer.
        shuffle_fields();
        bus.req = 4'b1000;
        @(posedge PCLK); #1;
        check_val("rst_grant3", 32'(bus.grant), 32'h8);
        @(negedge PCLK);
        PRESET  = 1'b1;
        bus.req = 4'b1001;
        @(posedge PCLK); #1;
        check_val("rst_abort", {bus.transfer, 4'(bus.req_done), 4'(bus.grant), bus.busy}, 10'h0);
        @(negedge PCLK);
        PRESET    = 1'b0;
        last_w    = NR - 1;
        run_txn(4'b1001, 2, 1'b0);

        for (int t = 0; t < 40; t++) begin
            run_txn(4'($urandom_range(1, 15)), $urandom_range(0, 20), $urandom_range(0, 3) == 0);
            idle_cycles($urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
